mem_bank_resp: RTL

//  Responder side of the client->SRAM-bank req/gnt interface: one instance per SRAM bank (16 in system).

---
 rtl/mem_intf_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mem_bank_resp.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_intf_pkg.sv
// ----------------------------------------------------------------------------
// mem_intf_pkg
// Shared sizing constants and types for the client -> SRAM-bank interface.
//   NUM_CLIENTS : number of requesting clients (req/gnt width)
//   DATA_W      : SRAM word width in bits
//   ROW_W       : bank row address width
//   ID_W        : client id width
//   bank_cmd_s  : one SRAM command as issued from the registered command stage
//   rd_tag_s    : tag carried alongside an in-flight read
//   rr_next()   : round-robin pointer advance with wrap
// ----------------------------------------------------------------------------
package mem_intf_pkg;

    localparam int NUM_CLIENTS = 16;
    localparam int DATA_W      = 256;
    localparam int ROW_W       = 10;
    localparam int ID_W        = $clog2(NUM_CLIENTS);

    typedef struct packed {
        logic              we;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] bwe;
    } bank_cmd_s;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_s;

    // Pointer position just after idx, wrapping the last client back to 0.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(NUM_CLIENTS - 1)) begin
            return {ID_W{1'b0}};
        end else begin
            return idx + ID_W'(1);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set request found when
// searching upward from rr_ptr_i, wrapping from N-1 back to 0.
//   req_i     : request vector
//   rr_ptr_i  : highest-priority index for this cycle
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_idx_o : index of the granted request (0 when none)
//   any_gnt_o : a grant was issued
// ----------------------------------------------------------------------------
module rr_arbiter
    import mem_intf_pkg::*;
#(
    parameter int N  = NUM_CLIENTS,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_gnt_o
);

    logic [IW-1:0] cand_s;
    logic          found_s;

    // Walk the requesters in priority order and keep the first hit.
    always_comb begin
        gnt_o     = {N{1'b0}};
        gnt_idx_o = {IW{1'b0}};
        found_s   = 1'b0;
        cand_s    = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(rr_ptr_i) + k) % N);
            if (!found_s && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                gnt_idx_o     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_gnt_o = found_s;
    end

endmodule

// File: rtl/mem_bank_resp.sv
// ----------------------------------------------------------------------------
// mem_bank_resp
// Responder for one SRAM bank: grants one client per cycle round-robin,
// drives the SRAM macro from a registered command stage and returns read
// data tagged with the requesting client's id.
//   clk, rst     : clock, asynchronous active-high reset
//   req/req_we/req_row/req_wdata/req_mask_en/req_mask : per-client request
//   gnt          : one-hot grant, combinational, same cycle as req
//   rvalid/rid/rdata : registered read response (rdata held until next rvalid)
//   sram_cs/we/row/wdata/bwe : registered SRAM command
//   sram_rdata   : SRAM read data, RD_LAT cycles after a read command
// Read latency from grant cycle to visible rvalid is RD_LAT+2 cycles.
// ----------------------------------------------------------------------------
module mem_bank_resp
    import mem_intf_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        req_we,
    input  logic [NUM_CLIENTS*ROW_W-1:0]  req_row,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_CLIENTS-1:0]        req_mask_en,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_mask,
    output logic [NUM_CLIENTS-1:0]        gnt,
    output logic                          rvalid,
    output logic [ID_W-1:0]               rid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [ROW_W-1:0]              sram_row,
    output logic [DATA_W-1:0]             sram_wdata,
    output logic [DATA_W-1:0]             sram_bwe,
    input  logic [DATA_W-1:0]             sram_rdata
);

    logic [NUM_CLIENTS-1:0] arb_gnt_s;
    logic [ID_W-1:0]        gnt_idx_s;
    logic                   any_gnt_s;

    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   cs_q, cs_d;
    bank_cmd_s              cmd_q, cmd_d;
    logic [ID_W-1:0]        cmd_id_q, cmd_id_d;
    rd_tag_s                tag_in_s;
    rd_tag_s                tag_q [RD_LAT];
    logic                   rvalid_q;
    logic [ID_W-1:0]        rid_q;
    logic [DATA_W-1:0]      rdata_q;

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .IW (ID_W)
    ) u_arb (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (arb_gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_gnt_o (any_gnt_s)
    );

    // No client may see a grant while the bank is held in reset.
    assign gnt = rst ? {NUM_CLIENTS{1'b0}} : arb_gnt_s;

    // Build the next SRAM command from the granted client's request.
    always_comb begin
        cs_d     = 1'b0;
        cmd_d    = '0;
        cmd_id_d = {ID_W{1'b0}};
        rr_ptr_d = rr_ptr_q;
        if (any_gnt_s) begin
            cs_d      = 1'b1;
            cmd_id_d  = gnt_idx_s;
            rr_ptr_d  = rr_next(gnt_idx_s);
            cmd_d.we  = req_we[gnt_idx_s];
            cmd_d.row = req_row[int'(gnt_idx_s)*ROW_W +: ROW_W];
            if (req_we[gnt_idx_s]) begin
                cmd_d.wdata = req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
                cmd_d.bwe   = req_mask_en[gnt_idx_s]
                            ? req_mask[int'(gnt_idx_s)*DATA_W +: DATA_W]
                            : {DATA_W{1'b1}};
            end else begin
                // Reads drive zero data and no bit enables.
                cmd_d.wdata = {DATA_W{1'b0}};
                cmd_d.bwe   = {DATA_W{1'b0}};
            end
        end else begin
            cs_d = 1'b0;
        end
    end

    // Round-robin pointer and registered SRAM command stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= {ID_W{1'b0}};
            cs_q     <= 1'b0;
            cmd_q    <= '0;
            cmd_id_q <= {ID_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cs_q     <= cs_d;
            cmd_q    <= cmd_d;
            cmd_id_q <= cmd_id_d;
        end
    end

    // A read enters the tag pipe the cycle its command is presented to the
    // macro, so the tail of the pipe lines up with valid sram_rdata.
    assign tag_in_s.valid = cs_q & ~cmd_q.we;
    assign tag_in_s.id    = cmd_id_q;

    // Read tag pipe, RD_LAT stages deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Response register: rvalid pulses, rid/rdata hold until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rid_q    <= {ID_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
        end else begin
            rvalid_q <= tag_q[RD_LAT-1].valid;
            if (tag_q[RD_LAT-1].valid) begin
                rid_q   <= tag_q[RD_LAT-1].id;
                rdata_q <= sram_rdata;
            end else begin
                rid_q   <= rid_q;
                rdata_q <= rdata_q;
            end
        end
    end

    assign sram_cs    = cs_q;
    assign sram_we    = cmd_q.we;
    assign sram_row   = cmd_q.row;
    assign sram_wdata = cmd_q.wdata;
    assign sram_bwe   = cmd_q.bwe;
    assign rvalid     = rvalid_q;
    assign rid        = rid_q;
    assign rdata      = rdata_q;

endmodule
